control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 imem_req  out  1 / imem_addr  out  32 / imem_ack  in  1 / imem_rdata  in  32: instruction fetch port, rdata valid when ack high.
REQ-005 alu_op  out  8 / alu_imm16  out  16: ALU function and immediate, driven from the instruction register (IR).
REQ-006 alu_zero, alu_neg, alu_ovf  in  1 each: ALU result flags.
REQ-007 rf_raddr1, rf_raddr2, rf_waddr  out  4 / rf_we  out  1 / rf_wsel  out  1: register file control; wsel 0 = ALU out, 1 = load data.
REQ-008 dmem_req  out  1 / dmem_we  out  1 / dmem_ack  in  1: data memory control; address is ALU out, external.
REQ-009 pc  out  32 / halted  out  1 / illegal  out  1: status.

Function
REQ-010 IR fields: [31:24] opcode, [23:20] rd, [19:16] rs1, [15:12] rs2, [15:0] imm16.
REQ-011 Opcode classes: R = 0x10-0x13; S = 0x21-0x27; B = 0x31 beq, 0x32 blt, 0x33 bgt; L = 0x41 load, 0x42 store; J = 0x51; HALT = 0xFF; all others illegal.
REQ-012 FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Reset enters IDLE; IDLE -> FETCH unconditionally.
REQ-013 FETCH: imem_req=1, imem_addr=pc; hold until imem_ack, then IR <= imem_rdata, go DECODE. imem_ack outside FETCH is ignored.
REQ-014 DECODE: one cycle; rf_raddr1=rs1, rf_raddr2=rs2 (stable from DECODE through WB); go EXEC.
REQ-015 EXEC: alu_op=opcode, alu_imm16=imm16; both held through MEM and WB. alu_op=0x00 in all other states.
REQ-016 EXEC exits: R/S -> WB; L -> MEM; B -> FETCH; J -> FETCH with pc <= {16'h0, imm16}; HALT -> HALT; illegal -> FETCH with illegal=1 for exactly that cycle and pc <= pc+1.
REQ-017 Branch taken: beq if alu_zero; blt if alu_neg; bgt if !alu_zero && !alu_neg. alu_ovf is ignored.
REQ-018 Branch target: taken pc <= pc + 1 + sign-extended imm16; not taken pc <= pc + 1.
REQ-019 MEM: dmem_req=1, dmem_we=1 for store only; hold until dmem_ack. On ack, load -> WB, store -> FETCH with pc <= pc+1.
REQ-020 WB: rf_we=1 for exactly one cycle, rf_waddr=rd, rf_wsel=1 for load else 0; pc <= pc+1; go FETCH.
REQ-021 PC arithmetic is modulo 2^32: 0xFFFF_FFFF + 1 = 0.
REQ-022 Latency with ack in the request cycle: R/S 4 cycles, load 5, store 4, branch/jump 3.
REQ-023 HALT: halted=1, no requests; sticky until reset.
REQ-024 rf_we, dmem_req, dmem_we and imem_req are never high in the same cycle.

Reset
REQ-025 rst_n low immediately forces, regardless of state: IDLE, pc=RESET_PC, IR=0, all request/strobe/status outputs 0, alu_op=0x00.
REQ-026 Reset mid-handshake abandons the transaction with no write; the first fetch after release is from RESET_PC.

Structure
REQ-027 Shared package cpu_pkg holds: opcode constants, state enum, IR field positions, and instruction-class enum; the ALU uses the same opcode constants.
REQ-028 One combinational sub-module, instr_decoder: opcode -> class, is_load, is_store, branch kind.

Verification
REQ-029 Reset with RESET_PC=0x100, release; ack immediately -> imem_addr=0x100 in cycle 2, IR loaded, states FETCH->DECODE.
REQ-030 Add instr 0x10_3_1_2000 -> alu_op=0x10 in EXEC; rf_we=1, waddr=3, wsel=0 for one cycle; pc 0x100->0x101; 4 cycles.
REQ-031 beq imm16=0xFFFE at pc=0x10: alu_zero=1 -> pc=0x0F; alu_zero=0 -> pc=0x11.
REQ-032 Load with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then rf_wsel=1, rf_we pulse.
REQ-033 Opcode 0x7E -> illegal pulse 1 cycle, no rf_we, pc+1; then 0xFF -> halted=1, imem_req stays 0.
REQ-034 rst_n low during store MEM wait -> dmem_req drops same cycle, no write; restart fetch at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-cycle CPU control path and its ALU:
//   - instruction register field positions and field extraction helpers
//   - opcode constants (the ALU decodes the same constants from alu_op)
//   - controller state enum, instruction-class enum, branch-kind enum
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    // Instruction register field positions
    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 24;
    localparam int unsigned RD_HI  = 23;
    localparam int unsigned RD_LO  = 20;
    localparam int unsigned RS1_HI = 19;
    localparam int unsigned RS1_LO = 16;
    localparam int unsigned RS2_HI = 15;
    localparam int unsigned RS2_LO = 12;
    localparam int unsigned IMM_HI = 15;
    localparam int unsigned IMM_LO = 0;

    // Idle ALU function, driven whenever the controller is not executing
    localparam logic [7:0] OP_NOP   = 8'h00;

    // R class: register-register ALU operations
    localparam logic [7:0] OP_ADD   = 8'h10;
    localparam logic [7:0] OP_SUB   = 8'h11;
    localparam logic [7:0] OP_AND   = 8'h12;
    localparam logic [7:0] OP_OR    = 8'h13;

    // S class: register-immediate ALU operations
    localparam logic [7:0] OP_ADDI  = 8'h21;
    localparam logic [7:0] OP_SUBI  = 8'h22;
    localparam logic [7:0] OP_ANDI  = 8'h23;
    localparam logic [7:0] OP_ORI   = 8'h24;
    localparam logic [7:0] OP_XORI  = 8'h25;
    localparam logic [7:0] OP_SLLI  = 8'h26;
    localparam logic [7:0] OP_SRLI  = 8'h27;

    // B class: conditional branches, decided from the ALU flags
    localparam logic [7:0] OP_BEQ   = 8'h31;
    localparam logic [7:0] OP_BLT   = 8'h32;
    localparam logic [7:0] OP_BGT   = 8'h33;

    // L class: data memory access
    localparam logic [7:0] OP_LOAD  = 8'h41;
    localparam logic [7:0] OP_STORE = 8'h42;

    // J class and halt
    localparam logic [7:0] OP_JMP   = 8'h51;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_S       = 3'd1,
        CLS_B       = 3'd2,
        CLS_L       = 3'd3,
        CLS_J       = 3'd4,
        CLS_HALT    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } iclass_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_LT   = 2'd2,
        BR_GT   = 2'd3
    } br_kind_e;

    function automatic logic [7:0] ir_opcode(input logic [XLEN-1:0] ir);
        return ir[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [3:0] ir_rd(input logic [XLEN-1:0] ir);
        return ir[RD_HI:RD_LO];
    endfunction

    function automatic logic [3:0] ir_rs1(input logic [XLEN-1:0] ir);
        return ir[RS1_HI:RS1_LO];
    endfunction

    function automatic logic [3:0] ir_rs2(input logic [XLEN-1:0] ir);
        return ir[RS2_HI:RS2_LO];
    endfunction

    function automatic logic [15:0] ir_imm16(input logic [XLEN-1:0] ir);
        return ir[IMM_HI:IMM_LO];
    endfunction

endpackage

// File: rtl/control_unit_instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
// Purely combinational opcode classifier for the control unit.
// Ports:
//   opcode_i    8-bit opcode from the instruction register
//   iclass_o    instruction class (R, S, B, L, J, HALT, ILLEGAL)
//   is_load_o   opcode is a load
//   is_store_o  opcode is a store
//   br_kind_o   branch condition for B-class opcodes, BR_NONE otherwise
// -----------------------------------------------------------------------------
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [7:0] opcode_i,
    output iclass_e    iclass_o,
    output logic       is_load_o,
    output logic       is_store_o,
    output br_kind_e   br_kind_o
);

    always_comb begin
        iclass_o   = CLS_ILLEGAL;
        is_load_o  = 1'b0;
        is_store_o = 1'b0;
        br_kind_o  = BR_NONE;

        if (opcode_i inside {[OP_ADD:OP_OR]}) begin
            iclass_o = CLS_R;
        end else if (opcode_i inside {[OP_ADDI:OP_SRLI]}) begin
            iclass_o = CLS_S;
        end else begin
            case (opcode_i)
                OP_BEQ: begin
                    iclass_o  = CLS_B;
                    br_kind_o = BR_EQ;
                end
                OP_BLT: begin
                    iclass_o  = CLS_B;
                    br_kind_o = BR_LT;
                end
                OP_BGT: begin
                    iclass_o  = CLS_B;
                    br_kind_o = BR_GT;
                end
                OP_LOAD: begin
                    iclass_o  = CLS_L;
                    is_load_o = 1'b1;
                end
                OP_STORE: begin
                    iclass_o   = CLS_L;
                    is_store_o = 1'b1;
                end
                OP_JMP:  iclass_o = CLS_J;
                OP_HALT: iclass_o = CLS_HALT;
                default: iclass_o = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Multi-cycle controller: fetches an instruction, decodes it, sequences the
// ALU, data memory and register-file write-back, and maintains the PC.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata    instruction fetch handshake (rdata valid on ack)
//   alu_op, alu_imm16          ALU function and immediate from the IR
//   alu_zero/neg/ovf           ALU result flags (ovf not used for branching)
//   rf_raddr1/2, rf_waddr      register file addresses
//   rf_we, rf_wsel             write strobe, write source (0 ALU, 1 load data)
//   dmem_req, dmem_we, dmem_ack data memory handshake (address is the ALU out)
//   pc, halted, illegal        status
// -----------------------------------------------------------------------------
module control_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,

    output logic [7:0]  alu_op,
    output logic [15:0] alu_imm16,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_ovf,

    output logic [3:0]  rf_raddr1,
    output logic [3:0]  rf_raddr2,
    output logic [3:0]  rf_waddr,
    output logic        rf_we,
    output logic        rf_wsel,

    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,

    output logic [31:0] pc,
    output logic        halted,
    output logic        illegal
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;

    iclass_e     iclass;
    logic        is_load;
    logic        is_store;
    br_kind_e    br_kind;
    logic        br_taken;
    logic [31:0] pc_next_seq;

    // Overflow has no meaning for the branch conditions used here.
    logic        unused_alu_ovf;
    assign unused_alu_ovf = alu_ovf;

    // Sequential successor; 32-bit addition wraps 0xFFFF_FFFF to 0.
    function automatic logic [31:0] pc_increment(input logic [31:0] pc_cur);
        return pc_cur + 32'd1;
    endfunction

    // Branch target is relative to the following instruction.
    function automatic logic [31:0] branch_target(input logic [31:0] pc_cur,
                                                  input logic [15:0] imm);
        logic signed [31:0] offset;
        offset = {{16{imm[15]}}, imm};
        return pc_cur + 32'd1 + $unsigned(offset);
    endfunction

    instr_decoder u_decoder (
        .opcode_i   (ir_opcode(ir_q)),
        .iclass_o   (iclass),
        .is_load_o  (is_load),
        .is_store_o (is_store),
        .br_kind_o  (br_kind)
    );

    assign pc_next_seq = pc_increment(pc_q);

    always_comb begin
        case (br_kind)
            BR_EQ:   br_taken = alu_zero;
            BR_LT:   br_taken = alu_neg;
            BR_GT:   br_taken = !alu_zero && !alu_neg;
            default: br_taken = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------------
    // State, PC and instruction registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            ir_q <= 32'h0000_0000;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  if (imem_ack) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                case (iclass)
                    CLS_R, CLS_S: state_d = ST_WB;
                    CLS_L:        state_d = ST_MEM;
                    CLS_HALT:     state_d = ST_HALT;
                    default:      state_d = ST_FETCH; // B, J and illegal
                endcase
            end
            ST_MEM: begin
                if (dmem_ack) state_d = is_load ? ST_WB : ST_FETCH;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // PC / IR update. imem_ack is only honoured while fetching.
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) ir_d = imem_rdata;
            end
            ST_EXEC: begin
                case (iclass)
                    CLS_B:       pc_d = br_taken ? branch_target(pc_q, ir_imm16(ir_q))
                                                 : pc_next_seq;
                    CLS_J:       pc_d = {16'h0000, ir_imm16(ir_q)};
                    CLS_ILLEGAL: pc_d = pc_next_seq;
                    default:     pc_d = pc_q;
                endcase
            end
            ST_MEM: begin
                if (dmem_ack && is_store) pc_d = pc_next_seq;
            end
            ST_WB:   pc_d = pc_next_seq;
            default: pc_d = pc_q;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output logic (decoded from the current state only, so reset clears
    // every strobe in the same cycle it is asserted)
    // ---------------------------------------------------------------------
    always_comb begin
        imem_req  = 1'b0;
        alu_op    = OP_NOP;
        alu_imm16 = 16'h0000;
        rf_raddr1 = 4'h0;
        rf_raddr2 = 4'h0;
        rf_waddr  = 4'h0;
        rf_we     = 1'b0;
        rf_wsel   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;

        // Read addresses held from DECODE through WB so operands stay stable.
        if (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
            rf_raddr1 = ir_rs1(ir_q);
            rf_raddr2 = ir_rs2(ir_q);
        end

        // ALU function held from EXEC through WB so the ALU result (also the
        // data memory address) stays valid until write-back.
        if (state_q inside {ST_EXEC, ST_MEM, ST_WB}) begin
            alu_op    = ir_opcode(ir_q);
            alu_imm16 = ir_imm16(ir_q);
        end

        case (state_q)
            ST_FETCH: imem_req = 1'b1;
            ST_EXEC:  illegal  = (iclass == CLS_ILLEGAL);
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
            end
            ST_WB: begin
                rf_we    = 1'b1;
                rf_waddr = ir_rd(ir_q);
                rf_wsel  = is_load;
            end
            ST_HALT:  halted   = 1'b1;
            default: ;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [7:0]  alu_op;
    logic [15:0] alu_imm16;
    logic        alu_zero, alu_neg, alu_ovf;
    logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic        rf_we, rf_wsel;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] pc;
    logic        halted, illegal;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_fetch_q[$];   // expected imem_addr per fetch handshake
    logic [4:0]  exp_wb_q[$];      // expected {rf_wsel, rf_waddr} per write-back
    logic        exp_dmem_q[$];    // expected dmem_we per data handshake

    control_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .alu_op     (alu_op),
        .alu_imm16  (alu_imm16),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg),
        .alu_ovf    (alu_ovf),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .rf_wsel    (rf_wsel),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .pc         (pc),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change at posedge+1, so the negedge sees settled handshakes.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("strobe_exclusive",
                {31'd0, ($countones({rf_we, dmem_req, imem_req}) <= 1) && (!dmem_we || dmem_req)},
                32'd1);
            if (imem_req && imem_ack) begin
                if (exp_fetch_q.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL fetch_unexpected: observed addr %0h expected no fetch", imem_addr);
                end else begin
                    chk("fetch_addr", imem_addr, exp_fetch_q.pop_front());
                end
            end
            if (rf_we) begin
                if (exp_wb_q.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL wb_unexpected: observed waddr %0h expected no write", rf_waddr);
                end else begin
                    chk("wb_sel_addr", {27'd0, rf_wsel, rf_waddr}, {27'd0, exp_wb_q.pop_front()});
                end
            end
            if (dmem_req && dmem_ack) begin
                if (exp_dmem_q.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL dmem_unexpected: observed we %0b expected no access", dmem_we);
                end else begin
                    chk("dmem_we", {31'd0, dmem_we}, {31'd0, exp_dmem_q.pop_front()});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a fetch request and answer it in the same cycle.
    task automatic issue(input logic [31:0] instr);
        int n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        if (!imem_req) begin
            checks++; errors++;
            $error("FAIL fetch_timeout: observed no imem_req expected one within 20 cycles");
        end
        imem_rdata = instr;
        imem_ack   = 1'b1;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic branch(input string tag, input logic [31:0] at_pc, input logic [31:0] instr,
                          input logic z, input logic n, input logic v, input logic [31:0] exp_pc);
        exp_fetch_q.push_back(at_pc);
        alu_zero = z; alu_neg = n; alu_ovf = v;
        issue(instr);
        step();                                  // EXEC
        step();                                  // back in FETCH
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_refetch"}, {31'd0, imem_req}, 32'd1);
        alu_zero = 1'b0; alu_neg = 1'b0; alu_ovf = 1'b0;
    endtask

    task automatic jump(input logic [31:0] at_pc, input logic [15:0] target);
        exp_fetch_q.push_back(at_pc);
        issue({8'h51, 8'h00, target});
        step();
        step();
        chk("jmp_pc", pc, {16'h0, target});
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; dmem_ack = 1'b0;
        alu_zero = 1'b0; alu_neg = 1'b0; alu_ovf = 1'b0;
        step();
        step();
        chk("rst_pc", pc, 32'h100);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_alu_op", {24'd0, alu_op}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);

        rst_n = 1'b1;
        chk("idle_no_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("c2_imem_req", {31'd0, imem_req}, 32'd1);
        chk("c2_imem_addr", imem_addr, 32'h100);

        // ADD r3 <- r1, r2
        exp_fetch_q.push_back(32'h100);
        exp_wb_q.push_back({1'b0, 4'd3});
        issue(32'h1031_2000);
        chk("add_dec_raddr1", {28'd0, rf_raddr1}, 32'd1);
        chk("add_dec_raddr2", {28'd0, rf_raddr2}, 32'd2);
        chk("add_dec_alu_idle", {24'd0, alu_op}, 32'd0);
        step();
        chk("add_exec_alu_op", {24'd0, alu_op}, 32'h10);
        chk("add_exec_imm", {16'd0, alu_imm16}, 32'h2000);
        step();
        chk("add_wb_we", {31'd0, rf_we}, 32'd1);
        chk("add_wb_alu_hold", {24'd0, alu_op}, 32'h10);
        step();
        chk("add_we_pulse", {31'd0, rf_we}, 32'd0);
        chk("add_pc", pc, 32'h101);
        chk("add_refetch", {31'd0, imem_req}, 32'd1);

        jump(32'h101, 16'h0010);
        branch("beq_taken",   32'h10, 32'h3100_FFFE, 1'b1, 1'b0, 1'b0, 32'h0F);
        jump(32'h0F, 16'h0010);
        branch("beq_nottaken", 32'h10, 32'h3100_FFFE, 1'b0, 1'b0, 1'b0, 32'h11);
        branch("blt_taken",   32'h11, 32'h3200_0005, 1'b0, 1'b1, 1'b0, 32'h17);
        branch("bgt_taken",   32'h17, 32'h3300_0002, 1'b0, 1'b0, 1'b1, 32'h1A);
        branch("bgt_nottaken", 32'h1A, 32'h3300_0002, 1'b0, 1'b1, 1'b0, 32'h1B);

        // LOAD r5 with data ack delayed 3 cycles
        exp_fetch_q.push_back(32'h1B);
        exp_wb_q.push_back({1'b1, 4'd5});
        exp_dmem_q.push_back(1'b0);
        issue(32'h4150_0000);
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            chk("ld_dmem_req", {31'd0, dmem_req}, 32'd1);
            chk("ld_dmem_we", {31'd0, dmem_we}, 32'd0);
            if (k == 3) dmem_ack = 1'b1;
            step();
        end
        dmem_ack = 1'b0;
        chk("ld_wb_we", {31'd0, rf_we}, 32'd1);
        chk("ld_wb_wsel", {31'd0, rf_wsel}, 32'd1);
        chk("ld_wb_no_dmem", {31'd0, dmem_req}, 32'd0);
        step();
        chk("ld_pc", pc, 32'h1C);
        chk("ld_we_pulse", {31'd0, rf_we}, 32'd0);

        // STORE, immediate ack
        exp_fetch_q.push_back(32'h1C);
        exp_dmem_q.push_back(1'b1);
        issue(32'h4206_0000);
        step();
        step();
        chk("st_dmem_we", {31'd0, dmem_we}, 32'd1);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("st_pc", pc, 32'h1D);
        chk("st_refetch", {31'd0, imem_req}, 32'd1);

        // Illegal opcode
        exp_fetch_q.push_back(32'h1D);
        issue(32'h7E00_0000);
        step();
        chk("ill_pulse", {31'd0, illegal}, 32'd1);
        chk("ill_no_we", {31'd0, rf_we}, 32'd0);
        step();
        chk("ill_pulse_end", {31'd0, illegal}, 32'd0);
        chk("ill_pc", pc, 32'h1E);

        // PC wrap: 0 -> 0xFFFF_FFFF via branch, then +1 -> 0
        jump(32'h1E, 16'h0000);
        branch("beq_wrap", 32'h0, 32'h3100_FFFE, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        exp_fetch_q.push_back(32'hFFFF_FFFF);
        exp_wb_q.push_back({1'b0, 4'd7});
        issue(32'h2171_0004);
        step();
        step();
        step();
        chk("wrap_pc", pc, 32'h0);

        // Reset during store MEM wait
        exp_fetch_q.push_back(32'h0);
        issue(32'h4200_0000);
        step();
        step();
        chk("st2_dmem_req", {31'd0, dmem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_mid_pc", pc, 32'h100);
        chk("rst_mid_alu_op", {24'd0, alu_op}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_refetch_addr", imem_addr, 32'h100);

        // HALT
        exp_fetch_q.push_back(32'h100);
        issue(32'hFF00_0000);
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            chk("halt_halted", {31'd0, halted}, 32'd1);
            chk("halt_no_req", {31'd0, imem_req}, 32'd0);
            step();
        end

        chk("fetch_q_drained", exp_fetch_q.size(), 32'd0);
        chk("wb_q_drained", exp_wb_q.size(), 32'd0);
        chk("dmem_q_drained", exp_dmem_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
